// File: rtl/decode_ibuffer.sv
// decode_ibuffer: in-order instruction buffer between fetch and decode with credit-based fetch requests and branch flush
module decode_ibuffer #(
   parameter int DEPTH            = 4,
   parameter int INSTR_W          = 32,
   parameter int FETCH_STATE_BITS = 2
) (
   input  logic                        clk_i,
   input  logic                        rstn_i,
   input  logic [INSTR_W:0]            fetch_info_i,
   output logic [FETCH_STATE_BITS-1:0] fetch_req_o,
   input  logic                        flush_i,
   output logic                        dec_valid_o,
   output logic [INSTR_W-1:0]          dec_instr_o,
   input  logic                        dec_ready_i,
   output logic [$clog2(DEPTH):0]      occupancy_o,
   output logic                        protocol_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [FETCH_STATE_BITS-1:0] F_NOPE = FETCH_STATE_BITS'(0);
   localparam logic [FETCH_STATE_BITS-1:0] F_KEEP = FETCH_STATE_BITS'(1);
   localparam logic [FETCH_STATE_BITS-1:0] F_NEXT = FETCH_STATE_BITS'(2);

   logic [INSTR_W-1:0] r_mem [DEPTH];
   logic [1:0]         r_state;
   logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]      r_count;
   logic               r_pending_q, r_protocol_err;
   logic [1:0]         w_state_nxt;
   logic [CW-1:0]      w_level;
   logic               w_in_valid, w_run, w_push, w_pop, w_err;

   assign w_in_valid  = fetch_info_i[INSTR_W];
   assign w_run       = r_state == S_RUN;
   // in-flight words count against capacity so a push never finds the FIFO full
   assign w_level     = r_count + CW'(r_pending_q);
   assign fetch_req_o = (w_run && !flush_i) ? ((w_level < CW'(DEPTH)) ? F_NEXT : F_KEEP) : F_NOPE;
   assign w_push      = w_in_valid && r_pending_q && w_run && !flush_i;
   assign w_err       = w_in_valid && !r_pending_q && r_state != S_FLUSH && !flush_i;
   assign dec_valid_o = r_count != '0 && w_run && !flush_i;
   assign w_pop       = dec_valid_o && dec_ready_i;
   assign dec_instr_o = r_mem[r_rd_ptr];
   assign occupancy_o = r_count;
   assign protocol_err_o = r_protocol_err;
   assign w_state_nxt = (r_state == S_IDLE) ? S_RUN : (flush_i ? S_FLUSH : S_RUN);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state        <= S_IDLE;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_pending_q    <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_pending_q    <= fetch_req_o == F_NEXT;
         r_protocol_err <= r_protocol_err || w_err;
         if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk_i)
      if (w_push) r_mem[r_wr_ptr] <= fetch_info_i[INSTR_W-1:0];
endmodule
